// File: rtl/assoc_datacache_pkg.sv
// rtl/assoc_datacache_pkg.sv - FSM encoding and address/line field helpers for assoc_datacache
package assoc_datacache_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOOKUP,
        S_WB,
        S_FILL,
        S_FWAIT,
        S_FLUSH
    } state_t;

    function automatic int off_w(int line_words, int word_w);
        return $clog2(line_words * word_w / 8);
    endfunction

    function automatic int word_off_w(int word_w);
        return $clog2(word_w / 8);
    endfunction

    function automatic int idx_w(int sets);
        return $clog2(sets);
    endfunction

    function automatic int tag_w(int addr_w, int line_words, int word_w, int sets);
        return addr_w - off_w(line_words, word_w) - idx_w(sets);
    endfunction

    function automatic int way_w(int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

    function automatic int wsel_w(int line_words);
        return (line_words > 1) ? $clog2(line_words) : 1;
    endfunction

    // Bit position of the selected word inside a line (word 0 in LSBs).
    function automatic int word_lsb(int wsel, int word_w);
        return wsel * word_w;
    endfunction

endpackage

// File: rtl/assoc_datacache_if.sv
// rtl/assoc_datacache_if.sv - CPU request/response, flush and line-memory handshake bundle
interface assoc_datacache_if #(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4
);
    localparam int LINE_W = LINE_WORDS * WORD_W;

    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [WORD_W-1:0] req_wdata;
    logic              resp_valid;
    logic [WORD_W-1:0] resp_rdata;
    logic              flush;
    logic              flush_done;
    logic              mem_req_valid;
    logic              mem_req_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [LINE_W-1:0] mem_wdata;
    logic              mem_resp_valid;
    logic [LINE_W-1:0] mem_rdata;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, flush,
        output mem_req_ready, mem_resp_valid, mem_rdata,
        input  req_ready, resp_valid, resp_rdata, flush_done,
        input  mem_req_valid, mem_we, mem_addr, mem_wdata
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, flush,
        input  mem_req_ready, mem_resp_valid, mem_rdata,
        output req_ready, resp_valid, resp_rdata, flush_done,
        output mem_req_valid, mem_we, mem_addr, mem_wdata
    );
endinterface

// File: rtl/assoc_datacache_plru.sv
// rtl/assoc_datacache_plru.sv - per-set tree pseudo-LRU bits; victim for the addressed set
module assoc_datacache_plru #(
    parameter int SETS  = 8,
    parameter int WAYS  = 2,
    parameter int IDX_W = 3,
    parameter int WAY_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [IDX_W-1:0] set_idx,
    input  logic [WAY_W-1:0] touch_way,
    input  logic             touch_en,
    output logic [WAY_W-1:0] victim
);
    generate
        if (WAYS == 1) begin : g_direct
            assign victim = '0;
        end else if (WAYS == 2) begin : g_two
            logic [SETS-1:0] lru_q;
            assign victim = lru_q[set_idx];
            always_ff @(posedge clk) begin
                if (rst) lru_q <= '0;
                else if (touch_en) lru_q[set_idx] <= ~touch_way[0];
            end
        end else begin : g_four
            // bit 0 picks the half, bits 1/2 pick within the left/right half
            logic [2:0] tree_q [SETS];
            assign victim = tree_q[set_idx][0] ? {1'b1, tree_q[set_idx][2]}
                                               : {1'b0, tree_q[set_idx][1]};
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) tree_q[s] <= '0;
                end else if (touch_en) begin
                    tree_q[set_idx][0] <= ~touch_way[1];
                    if (touch_way[1]) tree_q[set_idx][2] <= ~touch_way[0];
                    else              tree_q[set_idx][1] <= ~touch_way[0];
                end
            end
        end
    endgenerate
endmodule

// File: rtl/assoc_datacache.sv
// rtl/assoc_datacache.sv - N-way write-back write-allocate data cache; DCACHE_STATS_EN adds counters
module assoc_datacache
    import assoc_datacache_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int WORD_W     = 32,
    parameter int LINE_WORDS = 4,
    parameter int SETS       = 8,
    parameter int WAYS       = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    assoc_datacache_if.slave        bus
`ifdef DCACHE_STATS_EN
    ,
    output logic [31:0]             stat_hits,
    output logic [31:0]             stat_misses,
    output logic [31:0]             stat_wbs
`endif
);
    localparam int OFF_W  = off_w(LINE_WORDS, WORD_W);
    localparam int WOFF_W = word_off_w(WORD_W);
    localparam int IDX_W  = idx_w(SETS);
    localparam int TAG_W  = tag_w(ADDR_W, LINE_WORDS, WORD_W, SETS);
    localparam int WAY_W  = way_w(WAYS);
    localparam int WSEL_W = wsel_w(LINE_WORDS);
    localparam int LINE_W = LINE_WORDS * WORD_W;

    state_t                 state;
    logic [TAG_W-1:0]       tag_a   [SETS][WAYS];
    logic [LINE_W-1:0]      data_a  [SETS][WAYS];
    logic [SETS-1:0][WAYS-1:0] valid_q, dirty_q;

    logic                   flush_pend;
    logic                   r_we;
    logic [TAG_W-1:0]       r_tag;
    logic [IDX_W-1:0]       r_idx;
    logic [WSEL_W-1:0]      r_wsel;
    logic [WORD_W-1:0]      r_wdata;
    logic [WAY_W-1:0]       vway_q;
    logic [IDX_W-1:0]       fset;
    logic [WAY_W-1:0]       fway;

    logic                   resp_valid_q, flush_done_q, mem_req_valid_q, mem_we_q;
    logic [WORD_W-1:0]      resp_rdata_q;
    logic [ADDR_W-1:0]      mem_addr_q;
    logic [LINE_W-1:0]      mem_wdata_q;

    logic                   hit, inv_found;
    logic [WAY_W-1:0]       hit_way, inv_way, victim, plru_victim, touch_way;
    logic                   touch_en;
    logic [LINE_W-1:0]      hit_line, hit_merged, fill_merged;
    logic [WORD_W-1:0]      hit_word, fill_word;
    logic                   flush_last;

    assign bus.req_ready     = (state == S_IDLE) && !flush_pend && !bus.flush;
    assign bus.resp_valid    = resp_valid_q;
    assign bus.resp_rdata    = resp_rdata_q;
    assign bus.flush_done    = flush_done_q;
    assign bus.mem_req_valid = mem_req_valid_q;
    assign bus.mem_we        = mem_we_q;
    assign bus.mem_addr      = mem_addr_q;
    assign bus.mem_wdata     = mem_wdata_q;

    always_comb begin
        hit       = 1'b0;
        hit_way   = '0;
        inv_found = 1'b0;
        inv_way   = '0;
        for (int w = 0; w < WAYS; w++) begin
            if (valid_q[r_idx][w] && tag_a[r_idx][w] == r_tag) begin
                hit     = 1'b1;
                hit_way = WAY_W'(w);
            end
            if (!valid_q[r_idx][w] && !inv_found) begin
                inv_found = 1'b1;
                inv_way   = WAY_W'(w);
            end
        end
        victim = inv_found ? inv_way : plru_victim;
    end

    always_comb begin
        hit_line    = data_a[r_idx][hit_way];
        hit_word    = hit_line[word_lsb(int'(r_wsel), WORD_W) +: WORD_W];
        hit_merged  = hit_line;
        hit_merged[word_lsb(int'(r_wsel), WORD_W) +: WORD_W] = r_wdata;
        fill_word   = bus.mem_rdata[word_lsb(int'(r_wsel), WORD_W) +: WORD_W];
        fill_merged = bus.mem_rdata;
        fill_merged[word_lsb(int'(r_wsel), WORD_W) +: WORD_W] = r_wdata;
    end

    assign touch_en   = (state == S_LOOKUP && hit) || (state == S_FWAIT && bus.mem_resp_valid);
    assign touch_way  = (state == S_LOOKUP) ? hit_way : vway_q;
    assign flush_last = (fset == IDX_W'(SETS - 1)) && (fway == WAY_W'(WAYS - 1));

    assoc_datacache_plru #(.SETS(SETS), .WAYS(WAYS), .IDX_W(IDX_W), .WAY_W(WAY_W)) u_plru (
        .clk       (clk),
        .rst       (rst),
        .set_idx   (r_idx),
        .touch_way (touch_way),
        .touch_en  (touch_en),
        .victim    (plru_victim)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state           <= S_IDLE;
            valid_q         <= '0;
            dirty_q         <= '0;
            flush_pend      <= 1'b0;
            r_we            <= 1'b0;
            r_tag           <= '0;
            r_idx           <= '0;
            r_wsel          <= '0;
            r_wdata         <= '0;
            vway_q          <= '0;
            fset            <= '0;
            fway            <= '0;
            resp_valid_q    <= 1'b0;
            resp_rdata_q    <= '0;
            flush_done_q    <= 1'b0;
            mem_req_valid_q <= 1'b0;
            mem_we_q        <= 1'b0;
            mem_addr_q      <= '0;
            mem_wdata_q     <= '0;
        end else begin
            resp_valid_q <= 1'b0;
            flush_done_q <= 1'b0;
            if (bus.flush && state != S_FLUSH && state != S_IDLE) flush_pend <= 1'b1;
            case (state)
                S_IDLE: begin
                    if (bus.flush || flush_pend) begin
                        flush_pend <= 1'b0;
                        fset       <= '0;
                        fway       <= '0;
                        state      <= S_FLUSH;
                    end else if (bus.req_valid) begin
                        r_we    <= bus.req_we;
                        r_tag   <= bus.req_addr[ADDR_W-1 -: TAG_W];
                        r_idx   <= bus.req_addr[OFF_W +: IDX_W];
                        r_wsel  <= (LINE_WORDS > 1) ? bus.req_addr[WOFF_W +: WSEL_W] : '0;
                        r_wdata <= bus.req_wdata;
                        state   <= S_LOOKUP;
                    end
                end
                S_LOOKUP: begin
                    if (hit) begin
                        if (r_we) begin
                            data_a[r_idx][hit_way]  <= hit_merged;
                            dirty_q[r_idx][hit_way] <= 1'b1;
                        end
                        resp_rdata_q <= hit_word;
                        resp_valid_q <= 1'b1;
                        state        <= S_IDLE;
                    end else begin
                        vway_q          <= victim;
                        mem_req_valid_q <= 1'b1;
                        if (valid_q[r_idx][victim] && dirty_q[r_idx][victim]) begin
                            mem_we_q    <= 1'b1;
                            mem_addr_q  <= {tag_a[r_idx][victim], r_idx, {OFF_W{1'b0}}};
                            mem_wdata_q <= data_a[r_idx][victim];
                            state       <= S_WB;
                        end else begin
                            mem_we_q   <= 1'b0;
                            mem_addr_q <= {r_tag, r_idx, {OFF_W{1'b0}}};
                            state      <= S_FILL;
                        end
                    end
                end
                S_WB: begin
                    if (bus.mem_req_ready) begin
                        mem_we_q   <= 1'b0;
                        mem_addr_q <= {r_tag, r_idx, {OFF_W{1'b0}}};
                        state      <= S_FILL;
                    end
                end
                S_FILL: begin
                    if (bus.mem_req_ready) begin
                        mem_req_valid_q <= 1'b0;
                        state           <= S_FWAIT;
                    end
                end
                S_FWAIT: begin
                    if (bus.mem_resp_valid) begin
                        tag_a[r_idx][vway_q]   <= r_tag;
                        data_a[r_idx][vway_q]  <= r_we ? fill_merged : bus.mem_rdata;
                        valid_q[r_idx][vway_q] <= 1'b1;
                        dirty_q[r_idx][vway_q] <= r_we;
                        resp_rdata_q           <= fill_word;
                        resp_valid_q           <= 1'b1;
                        state                  <= S_IDLE;
                    end
                end
                S_FLUSH: begin
                    // mem_req_valid doubles as "write-back of (fset,fway) in flight"
                    if (mem_req_valid_q) begin
                        if (bus.mem_req_ready) begin
                            mem_req_valid_q     <= 1'b0;
                            dirty_q[fset][fway] <= 1'b0;
                        end
                    end else if (valid_q[fset][fway] && dirty_q[fset][fway]) begin
                        mem_req_valid_q <= 1'b1;
                        mem_we_q        <= 1'b1;
                        mem_addr_q      <= {tag_a[fset][fway], fset, {OFF_W{1'b0}}};
                        mem_wdata_q     <= data_a[fset][fway];
                    end
                    if ((mem_req_valid_q && bus.mem_req_ready) ||
                        (!mem_req_valid_q && !(valid_q[fset][fway] && dirty_q[fset][fway]))) begin
                        if (flush_last) begin
                            flush_done_q <= 1'b1;
                            state        <= S_IDLE;
                        end else if (fway == WAY_W'(WAYS - 1)) begin
                            fway <= '0;
                            fset <= fset + 1'b1;
                        end else begin
                            fway <= fway + 1'b1;
                        end
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

`ifdef DCACHE_STATS_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_hits   <= '0;
            stat_misses <= '0;
            stat_wbs    <= '0;
        end else begin
            if (state == S_LOOKUP && hit && stat_hits != '1) stat_hits <= stat_hits + 1'b1;
            if (state == S_LOOKUP && !hit && stat_misses != '1) stat_misses <= stat_misses + 1'b1;
            if (mem_req_valid_q && bus.mem_req_ready && mem_we_q && stat_wbs != '1)
                stat_wbs <= stat_wbs + 1'b1;
        end
    end
`endif
endmodule
